// File: rtl/simax_pkg.sv
// simax_pkg -- shared types for the MVM stream controller.
//
// Holds the controller FSM state enum, the two-bit mesh_state codes that
// the systolic mesh decodes, and a helper that maps one onto the other.
package simax_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_X,
        ST_COMPUTE,
        ST_DRAIN
    } state_t;

    // Mesh operating modes as seen on the mesh_state port.
    localparam logic [1:0] MS_IDLE = 2'b00;
    localparam logic [1:0] MS_LOAD = 2'b01;
    localparam logic [1:0] MS_COMP = 2'b10;
    localparam logic [1:0] MS_HOLD = 2'b11;

    // WAIT_X and DRAIN both ask the mesh to hold its contents.
    function automatic logic [1:0] mesh_code(input state_t s);
        case (s)
            ST_IDLE:    return MS_IDLE;
            ST_LOAD:    return MS_LOAD;
            ST_COMPUTE: return MS_COMP;
            default:    return MS_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/simax_narrow.sv
// simax_narrow -- narrows one mesh accumulator lane to the result lane width.
//
// Ports:
//   acc  in  ACC_W  signed accumulator value
//   res  out OUT_W  narrowed result
//
// Build option SIMAX_RESULT_SAT_EN: when defined, values outside the OUT_W
// signed range clamp to the most negative / most positive code; otherwise
// the low OUT_W bits are kept (two's-complement wrap). With OUT_W == ACC_W
// the lane passes straight through in both builds.
module simax_narrow #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] res
);

    generate
        if (OUT_W == ACC_W) begin : g_same
            assign res = acc;
        end else begin : g_narrow
`ifdef SIMAX_RESULT_SAT_EN
            localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
            localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
            // The value fits when every bit from the OUT_W sign position up
            // is a copy of the accumulator sign bit.
            logic [ACC_W-OUT_W:0] head;
            logic                 fits;
            assign head = acc[ACC_W-1:OUT_W-1];
            assign fits = (head == '0) || (head == '1);
            assign res  = fits ? acc[OUT_W-1:0] : (acc[ACC_W-1] ? SAT_MIN : SAT_MAX);
`else
            logic [ACC_W-OUT_W-1:0] unused_head;
            assign unused_head = acc[ACC_W-1:OUT_W];
            assign res         = acc[OUT_W-1:0];
`endif
        end
    endgenerate

endmodule

// File: rtl/mvm_stream_ctrl.sv
// mvm_stream_ctrl -- job controller for a ROWS x COLS weight-stationary mesh.
//
// A job optionally streams ROWS*COLS weights (row-major) into the mesh,
// then runs batch_len input vectors through it, one at a time. Each vector
// is latched into mesh_x, the mesh is given LAT compute cycles, and the
// result lanes are narrowed and parked in a single-entry output buffer.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   start, skip_load, batch_len       job launch (sampled in IDLE)
//   abort                             cancel job, highest priority
//   w_valid/w_ready/w_data            weight stream
//   x_valid/x_ready/x_data            input vector stream
//   out_valid/out_ready/out_data/out_last  result stream
//   mesh_state, cfg_valid, cfg_addr, cfg_data, mesh_x, mesh_result  mesh side
//   busy, done                        status; done pulses on final handshake
//
// Build option SIMAX_RESULT_SAT_EN selects saturating lane narrowing
// (see simax_narrow).
module mvm_stream_ctrl
    import simax_pkg::*;
#(
    parameter int DW      = 8,
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int ROW_W   = 4,
    parameter int COL_W   = 4,
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 16,
    parameter int LAT     = 2*ROWS,
    parameter int BATCH_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     skip_load,
    input  logic [BATCH_W-1:0]       batch_len,
    input  logic                     abort,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [DW-1:0]            w_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [COLS*DW-1:0]       x_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROWS*OUT_W-1:0]    out_data,
    output logic                     out_last,
    output logic [1:0]               mesh_state,
    output logic                     cfg_valid,
    output logic [ROW_W+COL_W-1:0]   cfg_addr,
    output logic [DW-1:0]            cfg_data,
    output logic [COLS*DW-1:0]       mesh_x,
    input  logic [ROWS*ACC_W-1:0]    mesh_result,
    output logic                     busy,
    output logic                     done
);

    localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_t                  state_reg, state_next;
    logic [ROW_W-1:0]        row_reg, row_next;
    logic [COL_W-1:0]        col_reg, col_next;
    logic [LAT_W-1:0]        lat_reg, lat_next;
    logic [BATCH_W-1:0]      vec_reg, vec_next;
    logic [BATCH_W-1:0]      len_reg, len_next;
    logic [COLS*DW-1:0]      mesh_x_reg, mesh_x_next;
    logic [ROWS*OUT_W-1:0]   out_data_reg, out_data_next;
    logic                    out_valid_reg, out_valid_next;
    logic                    out_last_reg, out_last_next;

    logic [ROWS*OUT_W-1:0]   narrowed;
    logic                    w_fire, x_fire, out_fire;
    logic                    last_beat, last_lat, last_vec;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_lane
            simax_narrow #(
                .ACC_W (ACC_W),
                .OUT_W (OUT_W)
            ) u_narrow (
                .acc (mesh_result[gi*ACC_W +: ACC_W]),
                .res (narrowed[gi*OUT_W +: OUT_W])
            );
        end
    endgenerate

    // Handshake and status outputs. abort gates the readies so nothing is
    // accepted in the cycle a job is being cancelled.
    assign w_ready    = (state_reg == ST_LOAD) && !abort;
    assign x_ready    = (state_reg == ST_WAIT_X) && (!out_valid_reg || out_ready) && !abort;
    assign w_fire     = w_valid && w_ready;
    assign x_fire     = x_valid && x_ready;
    assign out_fire   = out_valid_reg && out_ready;

    assign cfg_valid  = w_fire;
    assign cfg_addr   = {row_reg, col_reg};
    assign cfg_data   = (state_reg == ST_LOAD) ? w_data : '0;
    assign mesh_state = mesh_code(state_reg);
    assign mesh_x     = mesh_x_reg;
    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign out_last   = out_last_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DRAIN) && out_fire && !abort;

    assign last_beat  = (row_reg == ROW_W'(ROWS-1)) && (col_reg == COL_W'(COLS-1));
    assign last_lat   = (lat_reg == LAT_W'(LAT-1));
    assign last_vec   = (vec_reg == len_reg - BATCH_W'(1));

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        lat_next       = lat_reg;
        vec_next       = vec_reg;
        len_next       = len_reg;
        mesh_x_next    = mesh_x_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;

        if (out_fire) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    len_next   = (batch_len == '0) ? BATCH_W'(1) : batch_len;
                    vec_next   = '0;
                    state_next = skip_load ? ST_WAIT_X : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_fire) begin
                    if (last_beat) begin
                        row_next   = '0;
                        col_next   = '0;
                        state_next = ST_WAIT_X;
                    end else if (col_reg == COL_W'(COLS-1)) begin
                        col_next = '0;
                        row_next = row_reg + ROW_W'(1);
                    end else begin
                        col_next = col_reg + COL_W'(1);
                    end
                end
            end
            ST_WAIT_X: begin
                if (x_fire) begin
                    mesh_x_next = x_data;
                    lat_next    = '0;
                    state_next  = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                // The buffer is always empty here: x is only accepted when
                // the previous result leaves in the same cycle or earlier.
                if (last_lat) begin
                    out_data_next  = narrowed;
                    out_valid_next = 1'b1;
                    out_last_next  = last_vec;
                    lat_next       = '0;
                    vec_next       = vec_reg + BATCH_W'(1);
                    state_next     = last_vec ? ST_DRAIN : ST_WAIT_X;
                end else begin
                    lat_next = lat_reg + LAT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    vec_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (abort) begin
            state_next     = ST_IDLE;
            row_next       = '0;
            col_next       = '0;
            lat_next       = '0;
            vec_next       = '0;
            len_next       = '0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            lat_reg       <= '0;
            vec_reg       <= '0;
            len_reg       <= '0;
            mesh_x_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            lat_reg       <= lat_next;
            vec_reg       <= vec_next;
            len_reg       <= len_next;
            mesh_x_reg    <= mesh_x_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
        end
    end

endmodule

// File: tb/tb_mvm_stream_ctrl.sv
// tb_mvm_stream_ctrl -- directed bench for mvm_stream_ctrl (ACC_W=20, OUT_W=16).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_mvm_stream_ctrl;
    import simax_pkg::*;

    localparam int DW      = 8;
    localparam int ROWS    = 16;
    localparam int COLS    = 16;
    localparam int ROW_W   = 4;
    localparam int COL_W   = 4;
    localparam int ACC_W   = 20;
    localparam int OUT_W   = 16;
    localparam int LAT     = 2*ROWS;
    localparam int BATCH_W = 8;

`ifdef SIMAX_RESULT_SAT_EN
    localparam logic [15:0] EXP_L0 = 16'h7FFF;
    localparam logic [15:0] EXP_L1 = 16'h8000;
`else
    localparam logic [15:0] EXP_L0 = 16'hFFF0;
    localparam logic [15:0] EXP_L1 = 16'h0005;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   start, skip_load, abort;
    logic [BATCH_W-1:0]     batch_len;
    logic                   w_valid, w_ready;
    logic [DW-1:0]          w_data;
    logic                   x_valid, x_ready;
    logic [COLS*DW-1:0]     x_data;
    logic                   out_valid, out_ready, out_last;
    logic [ROWS*OUT_W-1:0]  out_data;
    logic [1:0]             mesh_state;
    logic                   cfg_valid;
    logic [ROW_W+COL_W-1:0] cfg_addr;
    logic [DW-1:0]          cfg_data;
    logic [COLS*DW-1:0]     mesh_x;
    logic [ROWS*ACC_W-1:0]  mesh_result;
    logic                   busy, done;

    logic [ROWS*OUT_W-1:0]  exp_out;
    logic [COLS*DW-1:0]     xa, xb;
    int n_cmp = 0;
    int n_bad = 0;

    mvm_stream_ctrl #(
        .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .ACC_W(ACC_W), .OUT_W(OUT_W), .LAT(LAT), .BATCH_W(BATCH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .skip_load(skip_load),
        .batch_len(batch_len), .abort(abort),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mesh_state(mesh_state), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .mesh_x(mesh_x), .mesh_result(mesh_result), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Small lane values that fit OUT_W, so narrowing is just truncation.
    task automatic set_result(input int base);
        for (int r = 0; r < ROWS; r++) begin
            mesh_result[r*ACC_W +: ACC_W] = ACC_W'(base + r);
            exp_out[r*OUT_W +: OUT_W]     = OUT_W'(base + r);
        end
    endtask

    function automatic logic [COLS*DW-1:0] xpat(input int s);
        logic [COLS*DW-1:0] p;
        for (int c = 0; c < COLS; c++) p[c*DW +: DW] = DW'(s*7 + c);
        return p;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; skip_load = 1'b0; batch_len = '0; abort = 1'b0;
        w_valid = 1'b1; w_data = 8'hA5; x_valid = 1'b0; x_data = '0;
        out_ready = 1'b0; mesh_result = '0; exp_out = '0;

        // ---- reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_mesh_state", mesh_state, MS_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_w_ready", w_ready, 1'b0);
        check("rst_x_ready", x_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_cfg_valid", cfg_valid, 1'b0);
        check("rst_cfg_addr", cfg_addr, 8'h00);
        check("rst_cfg_data", cfg_data, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_mesh_x", mesh_x, '0);
        check("rst_out_data", out_data, '0);

        // ---- full weight load, batch of 3
        @(negedge clk); rst_n = 1'b1; w_valid = 1'b0;
        @(negedge clk); start = 1'b1; skip_load = 1'b0; batch_len = 8'd3; #1;
        check("idle_before_start", mesh_state, MS_IDLE);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); start = 1'b0; w_valid = 1'b1; w_data = DW'(i ^ 8'h5A); #1;
            check("load_cfg_valid", cfg_valid, 1'b1);
            check("load_cfg_addr", cfg_addr, i[7:0]);
            check("load_cfg_data", cfg_data, DW'(i ^ 8'h5A));
            check("load_mesh_state", mesh_state, MS_LOAD);
        end
        $display("load: 256 weights streamed");
        @(negedge clk); w_valid = 1'b0; #1;
        check("after_load_state", mesh_state, MS_HOLD);
        check("after_load_addr_wrap", cfg_addr, 8'h00);
        check("after_load_w_ready", w_ready, 1'b0);
        check("after_load_busy", busy, 1'b1);

        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            @(negedge clk); x_valid = 1'b1; x_data = xpat(v); #1;
            check("b3_x_ready", x_ready, 1'b1);
            set_result(16'h0100 * (v + 1));
            for (int k = 1; k <= LAT + 1; k++) begin
                @(negedge clk); x_valid = 1'b0; #1;
                if (k <= LAT) begin
                    check("b3_compute_state", mesh_state, MS_COMP);
                    check("b3_no_out_yet", out_valid, 1'b0);
                    check("b3_done_low", done, 1'b0);
                end else begin
                    check("b3_out_valid", out_valid, 1'b1);
                    check("b3_out_data", out_data, exp_out);
                    check("b3_mesh_x", mesh_x, xpat(v));
                    check("b3_out_last", out_last, (v == 2));
                    check("b3_done", done, (v == 2));
                    check("b3_hold_state", mesh_state, MS_HOLD);
                    $display("batch3 vec %0d: lane0=%h last=%0d", v, out_data[15:0], out_last);
                end
            end
        end
        @(negedge clk); #1;
        check("b3_end_state", mesh_state, MS_IDLE);
        check("b3_end_done", done, 1'b0);
        check("b3_end_busy", busy, 1'b0);

        // ---- back-pressure and narrowing, skip_load batch of 2
        @(negedge clk); start = 1'b1; skip_load = 1'b1; batch_len = 8'd2;
        out_ready = 1'b0; w_valid = 1'b1; w_data = 8'h33;
        @(negedge clk); start = 1'b0; #1;
        check("skip_state", mesh_state, MS_HOLD);
        check("skip_cfg_valid", cfg_valid, 1'b0);
        xa = xpat(9); xb = xpat(11);
        @(negedge clk); x_valid = 1'b1; x_data = xa; #1;
        check("bp_x_ready0", x_ready, 1'b1);
        set_result(16'h0200);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk); x_valid = 1'b0; #1;
        end
        @(negedge clk); x_valid = 1'b1; x_data = xb; #1;
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_out_data", out_data, exp_out);
        check("bp_out_last", out_last, 1'b0);
        check("bp_x_ready_blocked", x_ready, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            check("bp_x_ready_held", x_ready, 1'b0);
            check("bp_out_data_stable", out_data, exp_out);
            check("bp_mesh_x_stable", mesh_x, xa);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        check("bp_release_x_ready", x_ready, 1'b1);
        $display("backpressure: vec 0 lane0=%h released", out_data[15:0]);
        set_result(16'h0000);
        mesh_result[0*ACC_W +: ACC_W] = 20'h7FFF0;
        mesh_result[1*ACC_W +: ACC_W] = 20'h80005;
        mesh_result[2*ACC_W +: ACC_W] = 20'hFFFFE;
        exp_out[0*OUT_W +: OUT_W] = EXP_L0;
        exp_out[1*OUT_W +: OUT_W] = EXP_L1;
        exp_out[2*OUT_W +: OUT_W] = 16'hFFFE;
        @(negedge clk); out_ready = 1'b0; x_valid = 1'b0; #1;
        check("bp_buffer_empty", out_valid, 1'b0);
        check("bp_compute_state", mesh_state, MS_COMP);
        check("bp_mesh_x_new", mesh_x, xb);
        for (int k = 2; k <= LAT; k++) @(negedge clk);
        @(negedge clk); #1;
        check("nar_out_valid", out_valid, 1'b1);
        check("nar_out_last", out_last, 1'b1);
        check("nar_lane0", out_data[15:0], EXP_L0);
        check("nar_lane1", out_data[31:16], EXP_L1);
        check("nar_out_data", out_data, exp_out);
        check("nar_drain_state", mesh_state, MS_HOLD);
        check("nar_done_wait", done, 1'b0);
        $display("narrow: vec 1 lane0=%h lane1=%h", out_data[15:0], out_data[31:16]);
        @(negedge clk); #1;
        check("nar_done_still_low", done, 1'b0);
        @(negedge clk); out_ready = 1'b1; #1;
        check("nar_done_pulse", done, 1'b1);
        @(negedge clk); #1;
        check("nar_end_state", mesh_state, MS_IDLE);
        check("nar_end_done", done, 1'b0);
        check("nar_end_out_valid", out_valid, 1'b0);

        // ---- abort at LOAD beat 100, then restart
        @(negedge clk); start = 1'b1; skip_load = 1'b0; batch_len = 8'd1; w_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); w_valid = 1'b1; w_data = DW'(i); #1;
            check("ab_cfg_addr", cfg_addr, i[7:0]);
        end
        @(negedge clk); abort = 1'b1; #1;
        check("ab_beat100_addr", cfg_addr, 8'h64);
        check("ab_cfg_valid", cfg_valid, 1'b0);
        check("ab_w_ready", w_ready, 1'b0);
        check("ab_done", done, 1'b0);
        @(negedge clk); abort = 1'b0; w_valid = 1'b0; #1;
        check("ab_idle", mesh_state, MS_IDLE);
        check("ab_busy", busy, 1'b0);
        check("ab_addr_zero", cfg_addr, 8'h00);
        check("ab_no_done", done, 1'b0);
        $display("abort: load cancelled at beat 100");
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; w_valid = 1'b1; w_data = 8'hC3; #1;
        check("re_cfg_addr0", cfg_addr, 8'h00);
        check("re_cfg_valid", cfg_valid, 1'b1);
        check("re_state", mesh_state, MS_LOAD);
        @(negedge clk); #1;
        check("re_cfg_addr1", cfg_addr, 8'h01);

        // ---- asynchronous reset mid-load
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_state", mesh_state, MS_IDLE);
        check("mid_rst_addr", cfg_addr, 8'h00);
        check("mid_rst_w_ready", w_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1; w_valid = 1'b0;

        // ---- skip_load with batch_len = 0 -> one vector
        @(negedge clk); start = 1'b1; skip_load = 1'b1; batch_len = 8'd0;
        out_ready = 1'b1; w_valid = 1'b1; w_data = 8'h77;
        @(negedge clk); start = 1'b0; x_valid = 1'b1; x_data = xpat(5); #1;
        check("b0_state", mesh_state, MS_HOLD);
        check("b0_cfg_valid", cfg_valid, 1'b0);
        check("b0_x_ready", x_ready, 1'b1);
        set_result(16'h0300);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk); x_valid = 1'b0; #1;
            check("b0_cfg_valid_compute", cfg_valid, 1'b0);
        end
        @(negedge clk); #1;
        check("b0_out_valid", out_valid, 1'b1);
        check("b0_out_last", out_last, 1'b1);
        check("b0_out_data", out_data, exp_out);
        check("b0_done", done, 1'b1);
        $display("batch0 vec 0: lane0=%h last=%0d", out_data[15:0], out_last);
        @(negedge clk); #1;
        check("b0_end_state", mesh_state, MS_IDLE);
        check("b0_end_done", done, 1'b0);
        check("b0_end_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mvm_stream_ctrl.md
MVM_STREAM_CTRL -- requirements
Module: mvm_stream_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, operand width.
REQ-002 SHALL have parameters ROWS and COLS, default 16 each, mesh dimensions.
REQ-003 SHALL have parameters ROW_W and COL_W, default 4 each, index widths; ACC_W, default 16, mesh accumulator width; OUT_W, default 16, result lane width (OUT_W<=ACC_W).
REQ-004 SHALL have parameter LAT, default 2*ROWS, compute cycles per vector; BATCH_W, default 8, batch counter width.
REQ-005 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports start (in, 1, begin job), skip_load (in, 1, reuse weights, sampled with start), batch_len (in, BATCH_W, vectors per job, sampled with start) and abort (in, 1, cancel job).
REQ-007 SHALL have ports w_valid (in, 1), w_ready (out, 1) and w_data (in, DW, signed weight, row-major stream).
REQ-008 SHALL have ports x_valid (in, 1), x_ready (out, 1) and x_data (in, COLS*DW, input vector).
REQ-009 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_data (out, ROWS*OUT_W, result) and out_last (out, 1, final vector of batch).
REQ-010 SHALL have mesh-side ports mesh_state (out, 2), cfg_valid (out, 1), cfg_addr (out, ROW_W+COL_W), cfg_data (out, DW), mesh_x (out, COLS*DW) and mesh_result (in, ROWS*ACC_W).
REQ-011 SHALL have ports busy (out, 1) and done (out, 1, one-cycle pulse).

Function
REQ-012 SHALL implement states IDLE, LOAD, WAIT_X, COMPUTE and DRAIN.
REQ-013 mesh_state SHALL be 00 in IDLE, 01 in LOAD, 10 in COMPUTE and 11 in WAIT_X/DRAIN.
REQ-014 In IDLE, start=1 SHALL go to LOAD, or to WAIT_X if skip_load=1; start SHALL be ignored outside IDLE.
REQ-015 batch_len=0 at start SHALL be treated as 1.
REQ-016 In LOAD, w_ready SHALL be 1; each w_valid&&w_ready beat SHALL drive cfg_valid=1, cfg_data=w_data and cfg_addr={row,col} (row-major) in the same cycle.
REQ-017 After beat ROWS*COLS the FSM SHALL go to WAIT_X and the address counter SHALL wrap to 0.
REQ-018 In WAIT_X, x_ready SHALL be 1 iff !out_valid || out_ready.
REQ-019 An accepted x_data SHALL be registered into mesh_x, held stable through COMPUTE, and SHALL cause a transition to COMPUTE.
REQ-020 COMPUTE SHALL last exactly LAT cycles; on the last cycle mesh_result SHALL be captured into out_data with out_valid=1 on the next cycle.
REQ-021 Each lane SHALL be narrowed from ACC_W to OUT_W per REQ-030.
REQ-022 out_valid/out_data SHALL hold until out_ready; there SHALL be a single-entry output buffer.
REQ-023 out_last SHALL be 1 with the result of vector batch_len.
REQ-024 After the final capture the FSM SHALL enter DRAIN; on out_ready it SHALL return to IDLE and pulse done.
REQ-025 abort SHALL override all other inputs: next state IDLE, out_valid cleared, cfg_valid=0, counters zeroed and no done pulse.
REQ-026 busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 On rst_n=0, state SHALL be IDLE and all counters SHALL be 0.
REQ-028 On rst_n=0, mesh_x, out_data, cfg_addr and cfg_data SHALL be 0, and w_ready, x_ready, out_valid, out_last, cfg_valid, done and busy SHALL be 0.
REQ-029 Reset asserted mid-job SHALL discard the job; behaviour after release SHALL be identical to power-up.

Configuration
REQ-030 With SIMAX_RESULT_SAT_EN defined, narrowing SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; undefined, it SHALL keep the low OUT_W bits (two's-complement wrap).
REQ-031 When OUT_W==ACC_W, the macro SHALL have no effect.

Structure
REQ-032 Package simax_pkg SHALL hold the FSM state enum and the mesh_state codes (MS_IDLE, MS_LOAD, MS_COMP, MS_HOLD).
REQ-033 Per-lane narrowing SHALL be a sub-module simax_narrow (ACC_W in, OUT_W out), instantiated ROWS times.

Verification
REQ-034 Reset, start, skip_load=0, 256 weights with w_valid held high -> cfg_addr 0x00..0xFF on consecutive cycles, then WAIT_X, mesh_state=11.
REQ-035 batch_len=3 with out_ready=1 -> three results, each LAT+1 cycles after its x accept; out_last only on the third; done pulses once.
REQ-036 out_ready=0 for 10 cycles after first result -> x_ready=0 and out_data stable; release -> next x accepted in that cycle.
REQ-037 mesh_result lane0=0x7FFF0 with OUT_W=16, ACC_W=20 -> 0x7FFF with SIMAX_RESULT_SAT_EN defined, 0xFFF0 without.
REQ-038 abort during LOAD beat 100, then start with skip_load=0 -> cfg_addr restarts at 0x00; no done pulse from the aborted job.
REQ-039 start with skip_load=1 and batch_len=0 -> no cfg_valid, one vector processed, done after its output handshake.
